// File: rtl/reduce_gate_unit.sv
// ---------------------------------------------------------------------------
// reduce_gate_unit
//   Clocked bitwise reduction of one WIDTH-bit operand. AND, OR and XOR
//   (odd parity) are computed together and land on registered outputs one
//   cycle after in_valid is sampled. out_valid pulses for exactly the cycles
//   that carry a fresh result; results hold their last value otherwise.
//
//   Parameters:
//     WIDTH      operand width, 2..32
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset (outputs clear immediately)
//     in_valid   capture/reduce a on this edge
//     a          operand vector
//     out_valid  y_* carry a fresh result this cycle
//     y_and      reduction AND
//     y_or       reduction OR
//     y_xor      reduction XOR
//   Optional (macro REDUCE_GATE_INV_OUT_EN):
//     y_nand/y_nor/y_xnor  complements of the base outputs, same flop stage,
//                          reset to 1 so they stay complementary in reset.
// ---------------------------------------------------------------------------
module reduce_gate_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic             y_and,
  output logic             y_or,
`ifdef REDUCE_GATE_INV_OUT_EN
  output logic             y_xor,
  output logic             y_nand,
  output logic             y_nor,
  output logic             y_xnor
`else
  output logic             y_xor
`endif
);

  // {and, or, xor}
  logic [2:0] res_d, res_q;
  logic       vld_q;

  assign res_d = {&a, |a, ^a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= 3'b000;
    end else begin
      vld_q <= in_valid;
      // Results only move on a valid capture; otherwise they hold.
      if (in_valid) res_q <= res_d;
    end
  end

  assign out_valid = vld_q;
  assign y_and     = res_q[2];
  assign y_or      = res_q[1];
  assign y_xor     = res_q[0];

`ifdef REDUCE_GATE_INV_OUT_EN
  // Separate flops so the complements are registered, not gated after the
  // base flops; reset value 1 keeps them exact complements during reset.
  logic [2:0] inv_d, inv_q;

  assign inv_d = ~res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           inv_q <= 3'b111;
    else if (in_valid) inv_q <= inv_d;
  end

  assign y_nand = inv_q[2];
  assign y_nor  = inv_q[1];
  assign y_xnor = inv_q[0];
`endif

endmodule

// File: tb/tb_reduce_gate_unit.sv
// Scoreboarded bench for reduce_gate_unit: a WIDTH=4 instance for the main
// tests and a WIDTH=8 instance for the width sweep. Expected {and,or,xor}
// triples are hand-computed constants pushed at issue time; per-instance
// monitors pop and compare on every out_valid.
module tb_reduce_gate_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv4, iv8;
  logic [3:0] a4;
  logic [7:0] a8;
  logic       ov4, ya4, yo4, yx4;
  logic       ov8, ya8, yo8, yx8;
`ifdef REDUCE_GATE_INV_OUT_EN
  logic       yna4, yno4, yxn4;
  logic       yna8, yno8, yxn8;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0] q4[$];
  logic [2:0] q8[$];

  // Hand-computed {and,or,xor} for a = 0..15.
  logic [2:0] exp4 [16] = '{
    3'b000, 3'b011, 3'b011, 3'b010, 3'b011, 3'b010, 3'b010, 3'b011,
    3'b011, 3'b010, 3'b010, 3'b011, 3'b010, 3'b011, 3'b011, 3'b110};

  always #5 clk = ~clk;

  reduce_gate_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4),
    .out_valid(ov4), .y_and(ya4), .y_or(yo4),
`ifdef REDUCE_GATE_INV_OUT_EN
    .y_xor(yx4), .y_nand(yna4), .y_nor(yno4), .y_xnor(yxn4)
`else
    .y_xor(yx4)
`endif
  );

  reduce_gate_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8),
    .out_valid(ov8), .y_and(ya8), .y_or(yo8),
`ifdef REDUCE_GATE_INV_OUT_EN
    .y_xor(yx8), .y_nand(yna8), .y_nor(yno8), .y_xnor(yxn8)
`else
    .y_xor(yx8)
`endif
  );

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; monitors sample on
  // the falling edge.
  task automatic drive4(input logic v, input logic [3:0] av, input logic [2:0] e);
    iv4 = v; a4 = av;
    if (v) q4.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] av, input logic [2:0] e);
    iv8 = v; a8 = av;
    if (v) q8.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ov4) begin
      if (q4.size() == 0) chk("sb4_unexpected_valid", 3'b001, 3'b000);
      else begin
        logic [2:0] e;
        e = q4.pop_front();
        chk("sb4_result", {ya4, yo4, yx4}, e);
`ifdef REDUCE_GATE_INV_OUT_EN
        chk("sb4_inv", {yna4, yno4, yxn4}, ~e);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov8) begin
      if (q8.size() == 0) chk("sb8_unexpected_valid", 3'b001, 3'b000);
      else begin
        logic [2:0] e;
        e = q8.pop_front();
        chk("sb8_result", {ya8, yo8, yx8}, e);
      end
    end
  end

  initial begin
    rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; a4 = '0; a8 = '0;
    #3;
    chk("reset_out4", {ov4, ya4, yo4, yx4}, 3'b000);
    chk("reset_vld4", {2'b00, ov4}, 3'b000);
`ifdef REDUCE_GATE_INV_OUT_EN
    chk("reset_inv4", {yna4, yno4, yxn4}, 3'b111);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    drive4(1'b0, 4'h0, 3'b000);

    // Exhaustive sweep, back-to-back, then a=0.
    for (int i = 0; i < 16; i++) drive4(1'b1, 4'(i), exp4[i]);
    drive4(1'b1, 4'h0, 3'b000);
    drive4(1'b0, 4'h0, 3'b000);

    // Hold: outputs keep the 0111 result while a changes with in_valid low.
    drive4(1'b1, 4'b0111, 3'b011);
    drive4(1'b0, 4'b1111, 3'b000);
    chk("hold_vld", {2'b00, ov4}, 3'b000);
    chk("hold_val", {ya4, yo4, yx4}, 3'b011);
    drive4(1'b0, 4'b1111, 3'b000);
    chk("hold_val2", {ya4, yo4, yx4}, 3'b011);

    // Valid pipeline 1,0,1,1 -> out_valid 0,1,0,1,1.
    chk("pipe_v0", {2'b00, ov4}, 3'b000);
    drive4(1'b1, 4'b0001, 3'b011);
    chk("pipe_v1", {2'b00, ov4}, 3'b001);
    drive4(1'b0, 4'b0000, 3'b000);
    chk("pipe_v2", {2'b00, ov4}, 3'b000);
    drive4(1'b1, 4'b1100, 3'b010);
    chk("pipe_v3", {2'b00, ov4}, 3'b001);
    drive4(1'b1, 4'b1110, 3'b011);
    chk("pipe_v4", {2'b00, ov4}, 3'b001);
    drive4(1'b0, 4'b0000, 3'b000);

`ifdef REDUCE_GATE_INV_OUT_EN
    drive4(1'b1, 4'b1010, 3'b010);
    chk("inv_1010", {yna4, yno4, yxn4}, 3'b101);
    drive4(1'b0, 4'b0000, 3'b000);
`endif

    // Mid-cycle reset with a capture pending: outputs clear without an edge.
    drive4(1'b1, 4'b1111, 3'b110);
    drive4(1'b0, 4'b0000, 3'b000);
    iv4 = 1'b1; a4 = 4'b1111;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out", {ya4, yo4, yx4}, 3'b000);
    chk("async_rst_vld", {2'b00, ov4}, 3'b000);
`ifdef REDUCE_GATE_INV_OUT_EN
    chk("async_rst_inv", {yna4, yno4, yxn4}, 3'b111);
`endif
    @(posedge clk); #1;
    chk("rst_held", {ov4, ya4, yo4}, 3'b000);
    rst = 1'b0;
    drive4(1'b0, 4'b0000, 3'b000);
    chk("post_rst_idle", {ov4, ya4, yo4}, 3'b000);
    drive4(1'b1, 4'b1011, 3'b011);
    drive4(1'b0, 4'b0000, 3'b000);

    // WIDTH=8 sweep.
    drive8(1'b1, 8'hFF, 3'b110);
    drive8(1'b1, 8'h80, 3'b011);
    drive8(1'b1, 8'h00, 3'b000);
    drive8(1'b0, 8'h00, 3'b000);
    drive8(1'b0, 8'h00, 3'b000);

    chk("sb4_drained", 3'(q4.size()), 3'b000);
    chk("sb8_drained", 3'(q8.size()), 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
